dmem_dump_uart: RTL
===================

// Module: dmem_dump_uart
// PURPOSE
// - Reads a range of data memory out through the dmem debug read port and sends each byte on a UART line (8N1).
// - Drives the dmem debug address and consumes the debug read data.
// - Gives a host a view of processor memory without stopping the core.
// - Sits in the top level next to dmem and shares its clock domain.
// PARAMETERS
// ADDR_W        4    dmem address width; depth is 2**ADDR_W
// DATA_W        8    dmem word width; this is also the number of UART data bits
// CLKS_PER_BIT  868  clk cycles per UART bit (must be >= 2)
// PORTS
// clk            in   1       system clock; all state changes on the rising edge
// reset          in   1       asynchronous, active-low reset
// start          in   1       starts a dump; sampled only in IDLE
// abort          in   1       synchronous cancel; takes priority over every other input
// first_addr     in   ADDR_W  first address to send; latched when start is accepted
// last_addr      in   ADDR_W  last address to send (inclusive); latched when start is accepted
// addr_on_dmem   out  ADDR_W  address driven to the dmem debug read port
// data_on_dmem   in   DATA_W  combinational dmem read data for addr_on_dmem
// tx             out  1       UART serial output; idle level is 1
// busy           out  1       high in every state except IDLE
// done           out  1       one-cycle pulse after the stop bit of the last byte
// BEHAVIOUR
// - Reset (reset=0, asynchronous): state=IDLE, tx=1, busy=0, done=0, addr_on_dmem=0.
//   - Bit counter, baud counter and shift register also clear to 0.
// - States: IDLE, LOAD, START, DATA, STOP. busy = (state != IDLE).
// - IDLE: on an edge with start=1:
//   - cur<=first_addr, last<=last_addr, addr_on_dmem<=first_addr, state<=LOAD.
// - LOAD (exactly 1 cycle):
//   - shift<=data_on_dmem, tx<=0, baud<=0, state<=START.
//   - The byte is a snapshot: dmem writes during the frame do not change it.
// - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0] and state<=DATA.
// - DATA: send DATA_W bits LSB first, each held for CLKS_PER_BIT cycles.
//   - After the last bit: tx<=1, state<=STOP.
// - STOP: hold tx=1 for CLKS_PER_BIT cycles, then:
//   - If cur==last: done<=1 for one cycle, state<=IDLE. addr_on_dmem holds its last value.
//   - Otherwise: cur<=cur+1 (mod 2**ADDR_W), addr_on_dmem<=cur+1, state<=LOAD.
// - Timing:
//   - First tx falling edge occurs 2 edges after start is sampled.
//   - One frame is exactly (DATA_W+2)*CLKS_PER_BIT cycles.
//   - An extra 1-cycle idle gap (LOAD) separates consecutive frames.
// - Range rules:
//   - The address wraps from 2**ADDR_W-1 to 0.
//   - Bytes sent = ((last-first) mod 2**ADDR_W) + 1.
//   - first==last sends exactly one byte.
//   - last<first wraps through the top of memory (e.g. 14..1 sends 14,15,0,1).
// - start while busy is ignored (no queuing, no restart).
//   - start in the same cycle that done is pulsed is ignored.
//   - start in the following IDLE cycle is accepted.
// - abort=1 on any edge, any state:
//   - state<=IDLE, tx<=1, done<=0; no done pulse.
//   - addr_on_dmem holds its value.
//   - abort with start in IDLE: abort wins, start is dropped.
// - Reset asserted mid-frame: tx returns to 1 immediately (asynchronously); the dump is lost.
// TESTING (CLKS_PER_BIT=4)
// - Single byte:
//   - Stimulus: dmem[3]=0xA5, start with first=last=3.
//   - Response: tx = 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit; done pulses once; busy high for 41 cycles.
// - Wrap range:
//   - Stimulus: dmem[14]=0x11, dmem[15]=0x22, dmem[0]=0x33, dmem[1]=0x44, first=14, last=1.
//   - Response: four frames 0x11,0x22,0x33,0x44; addr_on_dmem steps 14,15,0,1.
// - Snapshot:
//   - Stimulus: core writes dmem[5] from 0x0F to 0xF0 during frame 5 of a 5..6 dump.
//   - Response: the byte sent is 0x0F; the next dump sends 0xF0.
// - Ignored start:
//   - Stimulus: pulse start mid-frame and again on the done cycle.
//   - Response: no extra frames; a start 1 cycle later begins a new dump.
// - Abort:
//   - Stimulus: abort during the DATA of byte 2 of a 0..3 dump.
//   - Response: tx=1 next cycle; busy=0; no done; the next start restarts cleanly.
// - Async reset:
//   - Stimulus: drop reset mid-DATA, between clock edges.
//   - Response: tx=1, busy=0, addr_on_dmem=0 without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_dump_uart_if.sv
// Debug read port between the memory dump engine and dmem.
// The master drives the address; the slave returns combinational read data for it.
interface dmem_dump_uart_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_on_dmem;
    logic [DATA_W-1:0] data_on_dmem;

    modport master (output addr_on_dmem, input data_on_dmem);
    modport slave (input addr_on_dmem, output data_on_dmem);
endinterface

// File: rtl/dmem_dump_uart.sv
// Streams an inclusive, wrapping address range of dmem out of a UART (8N1) line
// through the dmem debug read port, one snapshot byte per frame.
module dmem_dump_uart #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    dmem_dump_uart_if.master  dmem,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur, cur_n, last, last_n, addr_q, addr_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic              tx_q, tx_n, done_q, done_n;
    logic              baud_end;

    assign baud_end          = (baud == BAUD_LAST);
    assign dmem.addr_on_dmem = addr_q;
    assign tx                = tx_q;
    assign done              = done_q;
    assign busy              = (state != IDLE);
    assign state_dbg         = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cur     <= '0;
            last    <= '0;
            addr_q  <= '0;
            shift   <= '0;
            baud    <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            last    <= last_n;
            addr_q  <= addr_n;
            shift   <= shift_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
        end
    end

    // Handshake: start is taken only in IDLE with done low; busy covers the whole
    // dump and done pulses once after the final stop bit. abort overrides everything.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        last_n  = last;
        addr_n  = addr_q;
        shift_n = shift;
        baud_n  = baud;
        bit_n   = bit_cnt;
        tx_n    = tx_q;
        done_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            tx_n    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !done_q) begin
                        cur_n   = first_addr;
                        last_n  = last_addr;
                        addr_n  = first_addr;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    // Capture the byte once so core writes during the frame cannot tear it.
                    shift_n = dmem.data_on_dmem;
                    tx_n    = 1'b0;
                    baud_n  = '0;
                    state_n = START;
                end
                START: begin
                    if (baud_end) begin
                        baud_n  = '0;
                        bit_n   = '0;
                        tx_n    = shift[0];
                        state_n = DATA;
                    end else begin
                        baud_n = baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_n = '0;
                        if (bit_cnt == BIT_LAST) begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end else begin
                            shift_n = shift >> 1;
                            tx_n    = shift[1];
                            bit_n   = bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_n = baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_n = '0;
                        if (cur == last) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            cur_n   = cur + 1'b1;
                            addr_n  = cur + 1'b1;
                            state_n = LOAD;
                        end
                    end else begin
                        baud_n = baud + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
